// File: rtl/effect_sequencer.sv
// effect_sequencer: switch synchronizer/debouncer, priority encoder and the
// click-free effect change sequencer (fade-out, optional FIFO flush, select
// switch, fade-in) driving the audio datapath's mux select, gain and flush.
// Optional build macro: EFFECT_SEQ_FLUSH_TIMEOUT_EN bounds the FIFO flush to
// FLUSH_MAX cycles and raises a sticky flush_timeout flag when it expires.
module effect_sequencer #(
  parameter logic [15:0] DEB_CYCLES = 16'd50000,
  parameter logic [7:0]  GAIN_STEP  = 8'd4
`ifdef EFFECT_SEQ_FLUSH_TIMEOUT_EN
  ,
  parameter logic [15:0] FLUSH_MAX  = 16'd1024
`endif
) (
  input  logic       audio_clk,
  input  logic       reset,
  input  logic [3:0] control_raw,
  input  logic       sample_req,
  input  logic       fifo_empty,
  output logic [1:0] effect_sel,
  output logic [7:0] gain,
  output logic       fifo_flush,
  output logic       busy,
  output logic       flush_timeout
);

  typedef enum logic [2:0] {
    ST_RUN      = 3'd0,
    ST_FADE_OUT = 3'd1,
    ST_FLUSH    = 3'd2,
    ST_SWITCH   = 3'd3,
    ST_FADE_IN  = 3'd4
  } state_t;

  localparam logic [1:0] SEL_NONE     = 2'd0;
  localparam logic [1:0] SEL_SINE     = 2'd1;
  localparam logic [1:0] SEL_FEEDBACK = 2'd2;
  localparam logic [1:0] SEL_FILTER   = 2'd3;

  // Gain step down, clamped at silence.
  function automatic logic [7:0] sat_sub(input logic [7:0] a, input logic [7:0] b);
    return (a < b) ? 8'd0 : (a - b);
  endfunction

  // Gain step up, clamped at unity (8'hFF).
  function automatic logic [7:0] sat_add(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[8] ? 8'hFF : s[7:0];
  endfunction

  state_t     state_q, state_d;
  logic       busy_q, busy_d;
  logic [2:0] sync1_q, sync1_d;
  logic [2:0] sync2_q, sync2_d;
  logic [1:0] enc;
  logic [1:0] enc_prev_q, enc_prev_d;
  logic [15:0] deb_cnt_q, deb_cnt_d;
  logic [1:0] target_q, target_d;
  logic [1:0] effect_sel_q, effect_sel_d;
  logic [7:0] gain_q, gain_d;
  logic       stable;
  logic       flush_expire;
  logic       unused_ctrl;

  // Bit 3 of the switch bank has no meaning and is deliberately dropped.
  assign unused_ctrl = control_raw[3];

  // Two-stage synchronizer inputs for the three meaningful switches.
  always_comb begin
    sync1_d = control_raw[2:0];
    sync2_d = sync1_q;
  end

  // Priority encode: FEEDBACK wins over SINE, SINE over FILTER.
  always_comb begin
    enc = SEL_NONE;
    if (sync2_q[1])      enc = SEL_FEEDBACK;
    else if (sync2_q[0]) enc = SEL_SINE;
    else if (sync2_q[2]) enc = SEL_FILTER;
  end

  // Debounce: count consecutive cycles of an unchanged code; once it has held
  // long enough it becomes the target, which may change at any time.
  always_comb begin
    enc_prev_d = enc;
    if (enc != enc_prev_q)            deb_cnt_d = 16'd0;
    else if (deb_cnt_q == DEB_CYCLES) deb_cnt_d = deb_cnt_q;
    else                              deb_cnt_d = deb_cnt_q + 16'd1;
    stable   = (deb_cnt_q == DEB_CYCLES) && (enc == enc_prev_q);
    target_d = stable ? enc_prev_q : target_q;
  end

`ifdef EFFECT_SEQ_FLUSH_TIMEOUT_EN
  logic [15:0] flush_cnt_q, flush_cnt_d;
  logic        flush_to_q, flush_to_d;

  // Flush watchdog: counts cycles spent in FLUSH, the flag is sticky.
  always_comb begin
    flush_expire = (state_q == ST_FLUSH) && !fifo_empty &&
                   (flush_cnt_q == FLUSH_MAX - 16'd1);
    flush_cnt_d  = (state_q == ST_FLUSH) ? flush_cnt_q + 16'd1 : 16'd0;
    flush_to_d   = flush_to_q | flush_expire;
  end

  // Watchdog registers.
  always_ff @(posedge audio_clk) begin
    if (reset) begin
      flush_cnt_q <= 16'd0;
      flush_to_q  <= 1'b0;
    end else begin
      flush_cnt_q <= flush_cnt_d;
      flush_to_q  <= flush_to_d;
    end
  end

  assign flush_timeout = flush_to_q;
`else
  assign flush_expire  = 1'b0;
  assign flush_timeout = 1'b0;
`endif

  // FSM state register; busy is registered alongside the state.
  always_ff @(posedge audio_clk) begin
    if (reset) begin
      state_q <= ST_RUN;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
    end
  end

  // FSM next-state logic; a target that returns to the live effect reverses
  // the fade instead of completing the change.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN: begin
        if (target_q != effect_sel_q) state_d = ST_FADE_OUT;
      end
      ST_FADE_OUT: begin
        if (target_q == effect_sel_q) state_d = ST_FADE_IN;
        else if (gain_q == 8'd0)      state_d = (target_q == SEL_FILTER) ? ST_FLUSH : ST_SWITCH;
      end
      ST_FLUSH: begin
        if (fifo_empty || flush_expire) state_d = ST_SWITCH;
      end
      ST_SWITCH: begin
        state_d = ST_FADE_IN;
      end
      ST_FADE_IN: begin
        if (target_q != effect_sel_q) state_d = ST_FADE_OUT;
        else if (gain_q == 8'hFF)     state_d = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase
    busy_d = (state_d != ST_RUN);
  end

  // FSM outputs: gain stepping, select update and the flush pop request.
  always_comb begin
    gain_d       = gain_q;
    effect_sel_d = effect_sel_q;
    fifo_flush   = 1'b0;
    case (state_q)
      ST_FADE_OUT: begin
        if (sample_req && (target_q != effect_sel_q)) gain_d = sat_sub(gain_q, GAIN_STEP);
      end
      ST_FLUSH: begin
        fifo_flush = !fifo_empty;
      end
      ST_SWITCH: begin
        effect_sel_d = target_q;
      end
      ST_FADE_IN: begin
        if (sample_req && (target_q == effect_sel_q)) gain_d = sat_add(gain_q, GAIN_STEP);
      end
      default: ;
    endcase
  end

  // Synchronizer, debounce and datapath-control registers.
  always_ff @(posedge audio_clk) begin
    if (reset) begin
      sync1_q      <= 3'd0;
      sync2_q      <= 3'd0;
      enc_prev_q   <= SEL_NONE;
      deb_cnt_q    <= 16'd0;
      target_q     <= SEL_NONE;
      effect_sel_q <= SEL_NONE;
      gain_q       <= 8'd0;
    end else begin
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      enc_prev_q   <= enc_prev_d;
      deb_cnt_q    <= deb_cnt_d;
      target_q     <= target_d;
      effect_sel_q <= effect_sel_d;
      gain_q       <= gain_d;
    end
  end

  assign effect_sel = effect_sel_q;
  assign gain       = gain_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_effect_sequencer.sv
// Bench for effect_sequencer: scoreboard of expected gain values per
// sample_req, plus bounded waits on select/busy and a small FIFO model.
module tb_effect_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] control_raw;
  logic       sample_req;
  logic       fifo_empty;
  logic [1:0] effect_sel;
  logic [7:0] gain;
  logic       fifo_flush;
  logic       busy;
  logic       flush_timeout;

  int checks = 0;
  int errors = 0;
  int exp_q[$];
  int m_gain;
  int fifo_count = 0;
  int flush_cycles = 0;
  logic fifo_load = 1'b0;
  int   fifo_load_val = 0;
  logic fifo_stuck = 1'b0;

  effect_sequencer #(
    .DEB_CYCLES(16'd8),
    .GAIN_STEP (8'd4)
`ifdef EFFECT_SEQ_FLUSH_TIMEOUT_EN
    ,
    .FLUSH_MAX (16'd16)
`endif
  ) dut (
    .audio_clk    (clk),
    .reset        (reset),
    .control_raw  (control_raw),
    .sample_req   (sample_req),
    .fifo_empty   (fifo_empty),
    .effect_sel   (effect_sel),
    .gain         (gain),
    .fifo_flush   (fifo_flush),
    .busy         (busy),
    .flush_timeout(flush_timeout)
  );

  always #5 clk = ~clk;

  // Filter FIFO model: pops on fifo_flush, can be held non-empty.
  assign fifo_empty = fifo_stuck ? 1'b0 : (fifo_count == 0);
  always @(posedge clk) begin
    if (fifo_flush) flush_cycles <= flush_cycles + 1;
    if (fifo_load) fifo_count <= fifo_load_val;
    else if (fifo_flush && fifo_count > 0) fifo_count <= fifo_count - 1;
  end

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // One sample_req pulse; the expected gain is queued when driven and
  // compared once the DUT has registered the step.
  task automatic pulse(input int dir);
    int nxt;
    nxt = m_gain + dir * 4;
    if (nxt > 255) nxt = 255;
    if (nxt < 0) nxt = 0;
    m_gain = nxt;
    exp_q.push_back(m_gain);
    sample_req = 1'b1;
    @(negedge clk);
    sample_req = 1'b0;
    chk("gain_step", int'(gain), exp_q.pop_front());
    @(negedge clk);
  endtask

  task automatic fade(input int dir, input int n);
    for (int i = 0; i < n; i++) pulse(dir);
  endtask

  task automatic wait_busy(input logic v, input string tag, input int lim);
    int k;
    k = 0;
    while (busy !== v && k < lim) begin
      @(negedge clk);
      k++;
    end
    chk(tag, int'(busy), int'(v));
  endtask

  task automatic wait_sel(input int v, input string tag, input int lim);
    int k;
    k = 0;
    while (int'(effect_sel) != v && k < lim) begin
      @(negedge clk);
      k++;
    end
    chk(tag, int'(effect_sel), v);
  endtask

  task automatic load_fifo(input int n);
    fifo_load_val = n;
    fifo_load = 1'b1;
    @(negedge clk);
    fifo_load = 1'b0;
  endtask

  // Full change sequence with no flush expected to matter: fade out, new
  // select, fade in, back to RUN.
  task automatic change_to(input logic [3:0] sw, input int sel, input string tag);
    control_raw = sw;
    wait_busy(1'b1, {tag, "_busy"}, 40);
    fade(-1, 64);
    wait_sel(sel, {tag, "_sel"}, 100);
    fade(1, 64);
    repeat (2) @(negedge clk);
    chk({tag, "_idle"}, int'(busy), 0);
  endtask

  initial begin
    int base;
    logic seen_busy;
    reset = 1'b1;
    control_raw = 4'b0001;
    sample_req = 1'b0;
    m_gain = 0;
    repeat (2) @(negedge clk);
    chk("rst_sel", int'(effect_sel), 0);
    chk("rst_gain", int'(gain), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_flush", int'(fifo_flush), 0);
    chk("rst_timeout", int'(flush_timeout), 0);
    reset = 1'b0;

    // Power-up into SINE: gain already 0, so straight to the switch.
    wait_busy(1'b1, "pu_busy", 30);
    chk("pu_gain0", int'(gain), 0);
    wait_sel(1, "pu_sel", 10);
    fade(1, 64);
    repeat (2) @(negedge clk);
    chk("pu_idle", int'(busy), 0);
    chk("pu_unity", int'(gain), 255);

    // Priority: FEEDBACK beats SINE and FILTER; no flush involved.
    base = flush_cycles;
    change_to(4'b0111, 2, "prio");
    chk("prio_noflush", flush_cycles - base, 0);

    // FILTER with 5 words buffered: exactly 5 pops before the switch.
    load_fifo(5);
    base = flush_cycles;
    control_raw = 4'b0100;
    wait_busy(1'b1, "filt_busy", 40);
    fade(-1, 64);
    wait_sel(3, "filt_sel", 100);
    chk("filt_pops", flush_cycles - base, 5);
    chk("filt_fifo", fifo_count, 0);
    fade(1, 64);
    repeat (2) @(negedge clk);
    chk("filt_idle", int'(busy), 0);
    chk("filt_timeout", int'(flush_timeout), 0);

    // Glitch shorter than the debounce window is ignored.
    control_raw = 4'b0001;
    repeat (7) @(negedge clk);
    control_raw = 4'b0100;
    seen_busy = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (busy) seen_busy = 1'b1;
    end
    chk("glitch_busy", int'(seen_busy), 0);
    chk("glitch_gain", int'(gain), 255);
    chk("glitch_sel", int'(effect_sel), 3);

    // Reversal mid fade-out: gain frozen, then fades back in from there.
    control_raw = 4'b0010;
    wait_busy(1'b1, "rev_busy", 40);
    fade(-1, 20);
    control_raw = 4'b0100;
    repeat (20) @(negedge clk);
    chk("rev_hold", int'(gain), m_gain);
    chk("rev_sel", int'(effect_sel), 3);
    fade(1, 20);
    repeat (2) @(negedge clk);
    chk("rev_idle", int'(busy), 0);
    chk("rev_unity", int'(gain), 255);

`ifdef EFFECT_SEQ_FLUSH_TIMEOUT_EN
    // FIFO never drains: the watchdog forces the switch after 16 cycles.
    change_to(4'b0001, 1, "to_pre");
    fifo_stuck = 1'b1;
    base = flush_cycles;
    control_raw = 4'b0100;
    wait_busy(1'b1, "to_busy", 40);
    fade(-1, 64);
    wait_sel(3, "to_sel", 100);
    chk("to_pops", flush_cycles - base, 16);
    chk("to_flag", int'(flush_timeout), 1);
    fade(1, 64);
    repeat (2) @(negedge clk);
    chk("to_sticky", int'(flush_timeout), 1);
    fifo_stuck = 1'b0;
`endif

    // Reset mid fade returns everything to idle values.
    control_raw = 4'b0001;
    wait_busy(1'b1, "rst2_busy", 40);
    fade(-1, 3);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("rst2_sel", int'(effect_sel), 0);
    chk("rst2_gain", int'(gain), 0);
    chk("rst2_busy", int'(busy), 0);
    chk("rst2_flush", int'(fifo_flush), 0);
    chk("rst2_timeout", int'(flush_timeout), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
